// File: rtl/serial_full_subtractor.sv
// rtl/serial_full_subtractor.sv - bit-serial a - b - bin, LSB first, valid/ready in and out.
// Optional SERIAL_SUB_OVF_EN adds the two's-complement overflow output ovf.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             x_bit;
  logic             y_bit;
  logic             diff_d;
  logic             br_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  // Single full-subtractor cell fed by the operand LSBs and the registered borrow.
  always_comb begin
    x_bit  = a_q[0];
    y_bit  = b_q[0];
    diff_d = x_bit ^ y_bit ^ br_q;
    br_d   = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= {diff_d, diff_q[WIDTH-1:1]};
          br_q   <= br_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into the MSB differs from borrow out of it.
            ovf_q   <= br_q ^ br_d;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The final borrow stays in br_q throughout DONE, so it doubles as bout.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = br_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_subtractor.sv
// tb/tb_serial_full_subtractor.sv - scoreboard bench for serial_full_subtractor, WIDTH=8.
module tb_serial_full_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t q[$];

  serial_full_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    exp_t       m;
    logic [8:0] r;
    int         s;
    r    = {1'b0, av} - {1'b0, bv} - {8'b0, bi};
    s    = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    m.d  = r[7:0];
    m.bo = r[8];
`ifdef SERIAL_SUB_OVF_EN
    m.ov = (s > 127) || (s < -128);
`else
    m.ov = 1'b0;
`endif
    return m;
  endfunction

  function automatic exp_t observe();
    exp_t g;
    g.d  = diff;
    g.bo = bout;
`ifdef SERIAL_SUB_OVF_EN
    g.ov = ovf;
`else
    g.ov = 1'b0;
`endif
    return g;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL send_ready_timeout in_ready=%0b required=1", in_ready);
    end
    a = av;
    b = bv;
    bin = bi;
    in_valid = 1'b1;
    q.push_back(model(av, bv, bi));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid with out_ready high; returns after the handshake edge.
  task automatic collect(output exp_t got, output bit found);
    found = 0;
    got = '0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        got = observe();
        found = 1;
        break;
      end
      @(negedge clk);
    end
    if (found) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 8'hA5;
    b = 8'h3C;
    bin = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state in_ready=%0b out_valid=%0b diff=%h bout=%0b required 1 0 00 0",
               in_ready, out_valid, diff, bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf got=%0b required=0", ovf);
    end
`endif
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_latency;
    exp_t e;
    bit   bad = 0;
    out_ready = 1'b1;
    send(8'h5A, 8'h23, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1;
      @(negedge clk);
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL latency_busy in_ready/out_valid not 0/0 during SHIFT");
    end
    e = q.pop_front();
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL latency_done out_valid=%0b in_ready=%0b required 1 0", out_valid, in_ready);
    end
    n_vec++;
    if (observe() !== e) begin
      n_err++;
      $display("FAIL basic_5a_23 got=%h required=%h", observe(), e);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL after_handshake out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_borrow;
    exp_t got, e;
    bit   f;
    send(8'h00, 8'h01, 1'b0);
    collect(got, f);
    e = q.pop_front();
    n_vec++;
    if (!f || got !== e || e.d !== 8'hFF || e.bo !== 1'b1) begin
      n_err++;
      $display("FAIL borrow_00_01 found=%0b got=%h required=%h", f, got, e);
    end
    send(8'h10, 8'h10, 1'b1);
    collect(got, f);
    e = q.pop_front();
    n_vec++;
    if (!f || got !== e || e.d !== 8'hFF || e.bo !== 1'b1) begin
      n_err++;
      $display("FAIL borrow_10_10_bin found=%0b got=%h required=%h", f, got, e);
    end
  endtask

  task automatic test_ovf;
    exp_t got, e;
    bit   f;
    send(8'h80, 8'h01, 1'b0);
    collect(got, f);
    e = q.pop_front();
    n_vec++;
    if (!f || got !== e) begin
      n_err++;
      $display("FAIL ovf_80_01 found=%0b got=%h required=%h", f, got, e);
    end
    send(8'h7F, 8'hFF, 1'b0);
    collect(got, f);
    e = q.pop_front();
    n_vec++;
    if (!f || got !== e) begin
      n_err++;
      $display("FAIL ovf_7f_ff found=%0b got=%h required=%h", f, got, e);
    end
  endtask

  task automatic test_backpressure;
    exp_t e, got;
    bit   f = 0;
    out_ready = 1'b0;
    send(8'h33, 8'h44, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        f = 1;
        break;
      end
      @(negedge clk);
    end
    e = q.pop_front();
    n_vec++;
    if (!f || observe() !== e) begin
      n_err++;
      $display("FAIL bp_first found=%0b got=%h required=%h", f, observe(), e);
    end
    a = 8'hC3;
    b = 8'h12;
    bin = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (observe() !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold cycle=%0d got=%h in_ready=%0b out_valid=%0b required=%h 0 1",
                 i, observe(), in_ready, out_valid, e);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
    q.push_back(model(8'hC3, 8'h12, 1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accept in_ready=%0b required=0", in_ready);
    end
    collect(got, f);
    e = q.pop_front();
    n_vec++;
    if (!f || got !== e) begin
      n_err++;
      $display("FAIL bp_second found=%0b got=%h required=%h", f, got, e);
    end
  endtask

  task automatic test_reset_mid;
    exp_t got, e;
    bit   f;
    bit   pulse = 0;
    send(8'hAA, 8'h55, 1'b0);
    void'(q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_state in_ready=%0b out_valid=%0b diff=%h bout=%0b required 1 0 00 0",
               in_ready, out_valid, diff, bout);
    end
    for (int i = 0; i < 15; i++) begin
      if (out_valid) pulse = 1;
      @(negedge clk);
    end
    n_vec++;
    if (pulse) begin
      n_err++;
      $display("FAIL midreset_pulse out_valid=1 required=0");
    end
    send(8'h0F, 8'h05, 1'b0);
    collect(got, f);
    e = q.pop_front();
    n_vec++;
    if (!f || got !== e) begin
      n_err++;
      $display("FAIL midreset_next found=%0b got=%h required=%h", f, got, e);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   got_n = 0;
    int   pushed = 0;
    int   last = -1;
    int   cyc = 0;
    logic [7:0] av, bv;
    logic bi;
    out_ready = 1'b1;
    while (got_n < 16 && cyc < 400) begin
      if (out_valid) begin
        e = q.pop_front();
        n_vec++;
        if (observe() !== e) begin
          n_err++;
          $display("FAIL b2b_result idx=%0d got=%h required=%h", got_n, observe(), e);
        end
        if (last >= 0) begin
          n_vec++;
          if (cyc - last != 10) begin
            n_err++;
            $display("FAIL b2b_spacing idx=%0d got=%0d required=10", got_n, cyc - last);
          end
        end
        last = cyc;
        got_n++;
      end
      if (in_ready) begin
        if (pushed < 16) begin
          av = 8'($urandom);
          bv = 8'($urandom);
          bi = 1'($urandom);
          a = av;
          b = bv;
          bin = bi;
          in_valid = 1'b1;
          q.push_back(model(av, bv, bi));
          pushed++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (got_n != 16) begin
      n_err++;
      $display("FAIL b2b_count got=%0d required=16", got_n);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_latency();
    test_borrow();
    test_ovf();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_full_subtractor.md
# serial_full_subtractor

Bit-serial N-bit subtractor. It computes `a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart to the adder datapaths in the arithmetic library. Operands enter and results leave through valid/ready handshakes, so it drops between a producer and a consumer wherever area matters more than latency.

## Interface
- `WIDTH`, default 8, operand and result width in bits; legal range ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `in_valid`  in  1  operands `a`, `b`, `bin` are valid.
- `in_ready`  out  1  block can accept operands (high only in IDLE).
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow in.
- `out_valid`  out  1  result valid (high only in DONE).
- `out_ready`  in  1  consumer accepts result.
- `diff`  out  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  borrow out; 1 iff unsigned `a < b + bin`.
- `ovf`  out  1  two's-complement overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: load `a` and `b` into shift registers, load borrow register with `bin`, clear bit counter, go to SHIFT.
- **SHIFT**, each cycle, with `x` = a-reg LSB, `y` = b-reg LSB, `br` = borrow register:
  - `d = x ^ y ^ br`.
  - `br_next = (~x & y) | (~(x ^ y) & br)`.
  - Shift `d` into the diff register MSB (right shift); shift the a-reg and b-reg right.
  - Increment the counter (width `$clog2(WIDTH)+1`).
  - After the WIDTH-th bit, go to DONE. The counter wraps to 0 on that transition.
- **DONE**
  - `out_valid` = 1; `diff`, `bout` (and `ovf`) are held stable.
  - On `out_ready`: go to IDLE.
- `in_valid` is ignored outside IDLE. Operands are not re-sampled after acceptance, so input changes during SHIFT have no effect.
- There is no accept/complete overlap. One operation is in flight at a time.
- `diff` and `bout` are only meaningful while `out_valid` = 1.

## Timing
- Reset (`rst_n` low at an edge), effective that edge:
  - state = IDLE, `in_ready` = 1.
  - `out_valid` = 0, `diff` = 0, `bout` = 0, `ovf` = 0.
  - Counter, shift registers and borrow register = 0.
  - Reset has priority over any handshake sampled at the same edge.
- Reset mid-SHIFT or mid-DONE:
  - The operation is discarded and no `out_valid` pulse is produced.
  - The next operation is accepted from IDLE normally.
- Latency:
  - Acceptance at edge E0.
  - SHIFT occupies edges E0+1 … E0+WIDTH.
  - `out_valid` is high starting the cycle after edge E0+WIDTH.
- Result handshake at edge E1 (`out_valid & out_ready`):
  - `out_valid` = 0 and `in_ready` = 1 after E1.
  - Earliest next acceptance is at edge E1+1.
- Maximum throughput is one result per WIDTH+2 cycles, with `out_ready` tied high and `in_valid` always high.
- `out_ready` held low keeps DONE indefinitely with outputs frozen.
- `in_ready` and `out_valid` are pure decodes of the state register, with no combinational path from inputs.

## Configuration
- Macro `SERIAL_SUB_OVF_EN`.
- **Defined:**
  - An extra flop captures the borrow into the MSB stage during the final SHIFT cycle.
  - `ovf` = (borrow into MSB) XOR (borrow out of MSB), registered with the result and valid in DONE.
  - `ovf` is cleared on reset.
- **Undefined:** the `ovf` port and its flop do not exist. All other behaviour is identical.

## Test plan
Directed scenarios, with `WIDTH` = 8:
- `a`=0x5A, `b`=0x23, `bin`=0, accepted at edge E0 -> `diff`=0x37, `bout`=0, `ovf`=0; `out_valid` first high after E0+8; `in_ready` low from after E0 until after the output handshake.
- `a`=0x00, `b`=0x01, `bin`=0 -> `diff`=0xFF, `bout`=1, `ovf`=0. Then `a`=0x10, `b`=0x10, `bin`=1 -> `diff`=0xFF, `bout`=1.
- With `SERIAL_SUB_OVF_EN`: `a`=0x80, `b`=0x01, `bin`=0 -> `diff`=0x7F, `bout`=0, `ovf`=1. Then `a`=0x7F, `b`=0xFF -> `diff`=0x80, `bout`=1, `ovf`=1.
- Backpressure: `out_ready`=0 for 5 cycles in DONE, with `in_valid`=1 and new operands presented -> `diff`/`bout` unchanged, `in_ready`=0, new operands ignored. Raising `out_ready` completes the handshake; the new operands are accepted one cycle later.
- `rst_n` low for one edge during the 3rd SHIFT cycle -> after that edge: state IDLE, `out_valid`=0, `diff`=0, `in_ready`=1, and no result pulse. The following op `a`=0x0F, `b`=0x05 -> `diff`=0x0A, `bout`=0.
- Back-to-back: 16 random ops with `out_ready`=1 and `in_valid`=1 -> each result matches the reference model, spaced exactly 10 cycles apart.
